// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: datapath width, major opcodes, the ALU
// control code enumeration consumed by the execute-stage ALU, and the decoded
// bundle carried from decode to execute.
package riscv_pkg;

    // Datapath, immediate and pc width.
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // {alt bit, funct3} encoding understood by the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_t;

    typedef struct packed {
        alu_ctrl_t        alu_ctrl;
        logic             alu_src_imm;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             illegal;
        logic [XLEN-1:0]  pc;
    } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
//   slave  : view taken by decode_stage (accepts instructions, drives bundle)
//   master : view taken by the surrounding pipeline / testbench
interface decode_stage_if;
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_ctrl;
    logic            out_alu_src_imm;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_alu_src_imm, out_imm,
               out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_illegal, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_alu_src_imm, out_imm,
               out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_illegal, out_pc
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control and legality decoder.
//   opcode_i/funct3_i/funct7_i : instruction fields
//   alu_ctrl_o                 : ALU operation (ALU_ADD whenever illegal)
//   illegal_o                  : instruction outside the RV32I subset handled here
// FENCE and SYSTEM opcodes are not part of the handled subset and decode as illegal.
module alu_ctrl_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_ctrl_t  alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                if (funct7_i == 7'h00) begin
                    alu_ctrl_o = alu_ctrl_t'({1'b0, funct3_i});
                end else if (funct7_i == 7'h20 &&
                             (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
                    alu_ctrl_o = alu_ctrl_t'({1'b1, funct3_i});
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3_i)
                    3'b001: begin
                        if (funct7_i == 7'h00) alu_ctrl_o = ALU_SLL;
                        else                   illegal_o  = 1'b1;
                    end
                    3'b101: begin
                        if (funct7_i == 7'h00)      alu_ctrl_o = ALU_SRL;
                        else if (funct7_i == 7'h20) alu_ctrl_o = ALU_SRA;
                        else                        illegal_o  = 1'b1;
                    end
                    // Non-shift immediates: funct7 bits belong to the immediate.
                    default: alu_ctrl_o = alu_ctrl_t'({1'b0, funct3_i});
                endcase
            end
            OPC_BRANCH: begin
                // Equality compares subtract; ordered compares use slt/sltu.
                case (funct3_i)
                    3'b000, 3'b001: alu_ctrl_o = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_o = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl_o = ALU_SLTU;
                    default:        illegal_o  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                case (funct3_i)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: alu_ctrl_o = ALU_ADD;
                    default:                                illegal_o  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                case (funct3_i)
                    3'b000, 3'b001, 3'b010: alu_ctrl_o = ALU_ADD;
                    default:                illegal_o  = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: alu_ctrl_o = ALU_ADD;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a registered output slot and a one-entry skid buffer.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch handshake (in_valid/in_ready/in_instr/in_pc) and execute
//              handshake plus decoded bundle (out_valid/out_ready/out_*)
// in_ready is simply "skid empty", so it comes straight from a flop, and the
// skid absorbs the one bundle accepted in the cycle the output stalls.
module decode_stage
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_ctrl_t   dec_ctrl;
    logic        dec_illegal;
    decoded_t    dec;

    decoded_t    out_q, out_d, skid_q, skid_d;
    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic        in_fire, slot_free;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    alu_ctrl_dec u_alu_ctrl_dec (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .alu_ctrl_o (dec_ctrl),
        .illegal_o  (dec_illegal)
    );

    // Illegal instructions leave every index, immediate and control at zero.
    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.illegal = dec_illegal;
        if (!dec_illegal) begin
            dec.alu_ctrl = dec_ctrl;
            case (opcode)
                OPC_OP: begin
                    dec.rs1 = rs1; dec.rs2 = rs2; dec.rd = rd;
                    dec.reg_write = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.rs1 = rs1; dec.rd = rd; dec.imm = imm_i;
                    dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
                end
                OPC_LOAD: begin
                    dec.rs1 = rs1; dec.rd = rd; dec.imm = imm_i;
                    dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src_imm = 1'b1;
                end
                OPC_STORE: begin
                    dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_s;
                    dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_b;
                    dec.branch = 1'b1;
                end
                OPC_JAL: begin
                    dec.rd = rd; dec.imm = imm_j;
                    dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src_imm = 1'b1;
                end
                OPC_JALR: begin
                    dec.rs1 = rs1; dec.rd = rd; dec.imm = imm_i;
                    dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src_imm = 1'b1;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec.rd = rd; dec.imm = imm_u;
                    dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
                end
                default: ;
            endcase
            // x0 is hardwired; never request a write to it.
            if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        end
    end

    assign in_fire   = bus.in_valid & ~skid_valid_q;
    assign slot_free = ~out_valid_q | bus.out_ready;

    // When the slot frees up, a waiting skid entry has priority; the skid can
    // only be full while in_ready is low, so it never competes with a new input.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (slot_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d        = dec;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready        = ~skid_valid_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_alu_ctrl    = out_q.alu_ctrl;
    assign bus.out_alu_src_imm = out_q.alu_src_imm;
    assign bus.out_imm         = out_q.imm;
    assign bus.out_rs1         = out_q.rs1;
    assign bus.out_rs2         = out_q.rs2;
    assign bus.out_rd          = out_q.rd;
    assign bus.out_reg_write   = out_q.reg_write;
    assign bus.out_mem_read    = out_q.mem_read;
    assign bus.out_mem_write   = out_q.mem_write;
    assign bus.out_branch      = out_q.branch;
    assign bus.out_jump        = out_q.jump;
    assign bus.out_illegal     = out_q.illegal;
    assign bus.out_pc          = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, backpressure and
// reset-flush sequences, then randomized traffic against a reference decoder
// and an in-order scoreboard of accepted instructions.
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;
    exp_t sb[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sign-extend the low 'bits' bits of v using plain arithmetic.
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input logic s, input logic [31:0] im,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic rw, input logic mr, input logic mw,
                                input logic br, input logic jp, input logic ill);
        exp_t e;
        e = '{ctrl: c, src: s, imm: im, rs1: a, rs2: b, rd: d, rw: rw, mr: mr,
               mw: mw, br: br, jp: jp, ill: ill, pc: 32'd0};
        return e;
    endfunction

    // Reference decoder: format and legality from the ISA rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op  = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        logic legal;
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        im_i = sext(32'(ins[31:20]), 12);
        im_s = sext(32'({ins[31:25], ins[11:7]}), 12);
        im_b = sext((32'(ins[31]) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                    | (32'(ins[11:8]) << 1), 13);
        im_j = sext((32'(ins[31]) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                    | (32'(ins[30:21]) << 1), 21);
        im_u = ins & 32'hFFFF_F000;
        e = '0;
        legal = 1'b1;
        case (op)
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.ctrl = {f7[5], f3};
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.rw = 1;
            end
            7'h13: begin
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.ctrl = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.imm = im_i; e.rw = 1; e.src = 1;
            end
            7'h03: begin
                legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.imm = im_i;
                e.rw = 1; e.mr = 1; e.src = 1;
            end
            7'h23: begin
                legal = (f3 inside {3'd0, 3'd1, 3'd2});
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = im_s; e.mw = 1; e.src = 1;
            end
            7'h63: begin
                legal = !(f3 inside {3'd2, 3'd3});
                e.ctrl = (f3 < 3'd4) ? 4'b1000 : (f3 >= 3'd6 ? 4'b0011 : 4'b0010);
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = im_b; e.br = 1;
            end
            7'h6F: begin e.rd = ins[11:7]; e.imm = im_j; e.rw = 1; e.jp = 1; e.src = 1; end
            7'h67: begin
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.imm = im_i;
                e.rw = 1; e.jp = 1; e.src = 1;
            end
            7'h37, 7'h17: begin e.rd = ins[11:7]; e.imm = im_u; e.rw = 1; e.src = 1; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        e.pc = pc;
        return e;
    endfunction

    function automatic exp_t dut_bundle();
        exp_t e;
        e.ctrl = bus.out_alu_ctrl;  e.src = bus.out_alu_src_imm; e.imm = bus.out_imm;
        e.rs1  = bus.out_rs1;       e.rs2 = bus.out_rs2;         e.rd  = bus.out_rd;
        e.rw   = bus.out_reg_write; e.mr  = bus.out_mem_read;    e.mw  = bus.out_mem_write;
        e.br   = bus.out_branch;    e.jp  = bus.out_jump;        e.ill = bus.out_illegal;
        e.pc   = bus.out_pc;
        return e;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: called #1 after an edge; checks status against the
    // occupancy model, scores any out handshake, records any in handshake.
    task automatic cycle();
        logic inf, outf, hold, rst_now;
        exp_t snap, e;
        rst_now = rst;
        inf  = bus.in_valid & bus.in_ready;
        outf = bus.out_valid & bus.out_ready;
        chk1("in_ready_model", bus.in_ready, sb.size() < 2);
        chk1("out_valid_model", bus.out_valid, sb.size() > 0);
        if (outf && !rst_now) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got pc %h expected no bundle", bus.out_pc);
            end else begin
                e = sb.pop_front();
                chkb("bundle_order", dut_bundle(), e);
                delivered++;
                $display("txn %0d pc=%h ctrl=%h imm=%h illegal=%b", delivered,
                         bus.out_pc, bus.out_alu_ctrl, bus.out_imm, bus.out_illegal);
            end
        end
        hold = bus.out_valid & ~bus.out_ready & ~rst_now;
        snap = dut_bundle();
        if (inf && !rst_now) sb.push_back(ref_decode(bus.in_instr, bus.in_pc));
        @(posedge clk);
        #1;
        if (rst_now) sb.delete();
        if (hold) begin
            chk1("stall_valid_held", bus.out_valid, 1'b1);
            chkb("stall_bundle_held", dut_bundle(), snap);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(3) == 0) return r;
        r[6:0] = ops[$urandom_range(8)];
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            case ($urandom_range(3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: ;
            endcase
        end
        return r;
    endfunction

    vec_t tbl [18];

    initial begin
        int   d0;
        logic acc;
        exp_t ex;

        tbl[0]  = '{"add",      32'h002081B3, mk(4'h0,0,32'h0,       1,2,3, 1,0,0,0,0,0)};
        tbl[1]  = '{"sub",      32'h402081B3, mk(4'h8,0,32'h0,       1,2,3, 1,0,0,0,0,0)};
        tbl[2]  = '{"sltu",     32'h0020B1B3, mk(4'h3,0,32'h0,       1,2,3, 1,0,0,0,0,0)};
        tbl[3]  = '{"addi_m1",  32'hFFF00093, mk(4'h0,1,32'hFFFFFFFF,0,0,1, 1,0,0,0,0,0)};
        tbl[4]  = '{"srai",     32'h40335293, mk(4'hD,1,32'h00000403,6,0,5, 1,0,0,0,0,0)};
        tbl[5]  = '{"zero_ill", 32'h00000000, mk(4'h0,0,32'h0,       0,0,0, 0,0,0,0,0,1)};
        tbl[6]  = '{"lw",       32'h00812203, mk(4'h0,1,32'h8,       2,0,4, 1,1,0,0,0,0)};
        tbl[7]  = '{"sw",       32'h00532623, mk(4'h0,1,32'hC,       6,5,0, 0,0,1,0,0,0)};
        tbl[8]  = '{"beq",      32'h00208863, mk(4'h8,0,32'h10,      1,2,0, 0,0,0,1,0,0)};
        tbl[9]  = '{"bltu_neg", 32'hFE20EEE3, mk(4'h3,0,32'hFFFFFFFC,1,2,0, 0,0,0,1,0,0)};
        tbl[10] = '{"jal",      32'h008000EF, mk(4'h0,1,32'h8,       0,0,1, 1,0,0,0,1,0)};
        tbl[11] = '{"lui",      32'h123453B7, mk(4'h0,1,32'h12345000,0,0,7, 1,0,0,0,0,0)};
        tbl[12] = '{"add_x0",   32'h00208033, mk(4'h0,0,32'h0,       1,2,0, 0,0,0,0,0,0)};
        tbl[13] = '{"op_f7_01", 32'h022081B3, mk(4'h0,0,32'h0,       0,0,0, 0,0,0,0,0,1)};
        tbl[14] = '{"br_f3_2",  32'h0020A863, mk(4'h0,0,32'h0,       0,0,0, 0,0,0,0,0,1)};
        tbl[15] = '{"slli_f20", 32'h40331293, mk(4'h0,0,32'h0,       0,0,0, 0,0,0,0,0,1)};
        tbl[16] = '{"jalr",     32'h004100E7, mk(4'h0,1,32'h4,       2,0,1, 1,0,0,0,1,0)};
        tbl[17] = '{"auipc",    32'h00001517, mk(4'h0,1,32'h1000,    0,0,10,1,0,0,0,0,0)};

        // Reset state.
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chkb("reset_bundle", dut_bundle(), '0);

        // Directed vectors, one transaction each.
        foreach (tbl[i]) begin
            bus.in_valid = 1'b1; bus.in_instr = tbl[i].instr; bus.in_pc = 32'h1000 + i * 4;
            bus.out_ready = 1'b1;
            cycle();
            bus.in_valid = 1'b0;
            ex = tbl[i].exp;
            ex.pc = 32'h1000 + i * 4;
            chk1({"vec_valid_", tbl[i].name}, bus.out_valid, 1'b1);
            chkb({"vec_", tbl[i].name}, dut_bundle(), ex);
            cycle();
        end

        // Three back-to-back instructions while execute stalls for 3 cycles.
        d0 = delivered;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h100;
        chk1("bp_ready_first", bus.in_ready, 1'b1);
        cycle();
        bus.in_instr = 32'h402081B3; bus.in_pc = 32'h104;
        chk1("bp_ready_second", bus.in_ready, 1'b1);
        cycle();
        bus.in_instr = 32'h0020B1B3; bus.in_pc = 32'h108;
        chk1("bp_ready_low", bus.in_ready, 1'b0);
        cycle();
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = bus.in_ready;
            cycle();
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL bp_third_accept: got no accept expected accept within 10 cycles");
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) cycle();
        checks++;
        if (delivered - d0 != 3) begin
            errors++;
            $display("FAIL bp_delivered: got %0d expected 3", delivered - d0);
        end

        // Reset with both output slot and skid occupied.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'hFFF00093; bus.in_pc = 32'h200;
        cycle();
        bus.in_instr = 32'h00812203; bus.in_pc = 32'h204;
        cycle();
        bus.in_valid = 1'b0;
        chk1("rst_pre_full", bus.in_ready, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk1("rst_flush_out_valid", bus.out_valid, 1'b0);
        chk1("rst_flush_in_ready", bus.in_ready, 1'b1);
        chkb("rst_flush_bundle", dut_bundle(), '0);

        // Randomized traffic against the reference decoder.
        for (int n = 0; n < 1500; n++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_instr  = gen_instr();
            bus.in_pc     = $urandom & 32'hFFFF_FFFC;
            bus.out_ready = ($urandom_range(2) != 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
